// File: rtl/spi_cmd_decoder.sv
`timescale 1ns/1ps
// spi_cmd_decoder
// SPI mode-0 slave front end for the register bank. SCLK/SCSN/MOSI are
// oversampled in the SPI_CLK domain. Each frame carries a device byte
// {dev[6:0], rw}, then a register address byte, then data bytes as a burst.
// Matched writes produce one write_strobe per data byte. Matched reads return
// register data on MISO. Frames addressed to other chips are ignored.
//
// Ports
//   SPI_CLK      block clock, at least 8x SCLK_IN
//   RST_S1       asynchronous active-high reset
//   SCLK_IN      SPI clock (asynchronous)
//   SCSN_IN      SPI chip select, active-low (asynchronous)
//   MOSI_IN      SPI data from master (asynchronous)
//   MISO_OUT     SPI data to master; 0 whenever MISO_OE is low
//   MISO_OE      MISO pad enable, high only in the data phase of a matched read
//   dev_addr     this chip's bus address
//   address      register address to the register bank
//   data_wr      write data to the register bank
//   write_strobe one-cycle write pulse; address/data_wr stable while high
//   read_strobe  one-cycle read pulse; address stable while high
//   read_data    register bank read data, valid 1 SPI_CLK after read_strobe
module spi_cmd_decoder #(
    parameter logic [6:0]  BROADCAST_ADDR = 7'h7F,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       SPI_CLK,
    input  logic       RST_S1,
    input  logic       SCLK_IN,
    input  logic       SCSN_IN,
    input  logic       MOSI_IN,
    output logic       MISO_OUT,
    output logic       MISO_OE,
    input  logic [6:0] dev_addr,
    output logic [7:0] address,
    output logic [7:0] data_wr,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] read_data
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DEV    = 3'd1;
    localparam logic [2:0] ST_REG    = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_IGNORE = 3'd4;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] scsn_sync_q, scsn_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic       scsn_prev_q, scsn_prev_d;
    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_in_q, shift_in_d;
    logic       read_mode_q, read_mode_d;
    logic [7:0] address_q, address_d;
    logic [7:0] data_wr_q, data_wr_d;
    logic       write_strobe_q, write_strobe_d;
    logic       read_strobe_q, read_strobe_d;
    logic       cap1_q, cap1_d;
    logic       cap2_q, cap2_d;
    logic [7:0] miso_sr_q, miso_sr_d;

    logic       sclk_s, scsn_s, mosi_s;
    logic       rise_det, fall_det, scsn_fall, byte_end, miso_oe;
    logic [7:0] byte_in;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK_IN};
        scsn_sync_d = {scsn_sync_q[SYNC_STAGES-2:0], SCSN_IN};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI_IN};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        scsn_s      = scsn_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        scsn_prev_d = scsn_s;
        rise_det    = sclk_s & ~sclk_prev_q;
        fall_det    = ~sclk_s & sclk_prev_q;
        scsn_fall   = scsn_prev_q & ~scsn_s;
        byte_in     = {shift_in_q[6:0], mosi_s};
        byte_end    = rise_det && (bit_cnt_q == 3'd7);
        miso_oe     = (state_q == ST_DATA) && read_mode_q;
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_in_d     = shift_in_q;
        read_mode_d    = read_mode_q;
        address_d      = address_q;
        data_wr_d      = data_wr_q;
        write_strobe_d = 1'b0;
        read_strobe_d  = 1'b0;
        cap1_d         = read_strobe_q;
        cap2_d         = cap1_q;
        miso_sr_d      = miso_sr_q;

        // Post-increment after each write, so the strobe cycle sees the old address.
        if (write_strobe_q) begin
            address_d = address_q + 8'd1;
        end

        if (scsn_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            if (rise_det && (state_q != ST_IDLE)) begin
                shift_in_d = byte_in;
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (scsn_fall) begin
                        state_d   = ST_DEV;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DEV: begin
                    if (byte_end) begin
                        if ((byte_in[7:1] == dev_addr) ||
                            ((byte_in[7:1] == BROADCAST_ADDR) && !byte_in[0])) begin
                            state_d     = ST_REG;
                            read_mode_d = byte_in[0] && (byte_in[7:1] == dev_addr);
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_REG: begin
                    if (byte_end) begin
                        state_d       = ST_DATA;
                        address_d     = byte_in;
                        read_strobe_d = read_mode_q;
                    end
                end
                ST_DATA: begin
                    if (byte_end) begin
                        if (read_mode_q) begin
                            // Prefetch the next register for the following byte.
                            address_d     = address_q + 8'd1;
                            read_strobe_d = 1'b1;
                        end else begin
                            data_wr_d      = byte_in;
                            write_strobe_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Load wins over shift. The falling edge that trails a byte's last
        // rise (bit counter back at 0) must not shift, otherwise the freshly
        // loaded MSB would be lost before the master samples it.
        if (cap2_q) begin
            miso_sr_d = read_data;
        end else if (fall_det && (bit_cnt_q != 3'd0) && miso_oe) begin
            miso_sr_d = {miso_sr_q[6:0], 1'b0};
        end
    end

    // Synchronizers reset to 0 on SCSN so that releasing reset mid-frame with
    // chip select still low does not look like a new falling edge.
    always_ff @(posedge SPI_CLK or posedge RST_S1) begin
        if (RST_S1) begin
            sclk_sync_q    <= '0;
            scsn_sync_q    <= '0;
            mosi_sync_q    <= '0;
            sclk_prev_q    <= 1'b0;
            scsn_prev_q    <= 1'b0;
            state_q        <= ST_IDLE;
            bit_cnt_q      <= 3'd0;
            shift_in_q     <= 8'h00;
            read_mode_q    <= 1'b0;
            address_q      <= 8'h00;
            data_wr_q      <= 8'h00;
            write_strobe_q <= 1'b0;
            read_strobe_q  <= 1'b0;
            cap1_q         <= 1'b0;
            cap2_q         <= 1'b0;
            miso_sr_q      <= 8'h00;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            scsn_sync_q    <= scsn_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            sclk_prev_q    <= sclk_prev_d;
            scsn_prev_q    <= scsn_prev_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_in_q     <= shift_in_d;
            read_mode_q    <= read_mode_d;
            address_q      <= address_d;
            data_wr_q      <= data_wr_d;
            write_strobe_q <= write_strobe_d;
            read_strobe_q  <= read_strobe_d;
            cap1_q         <= cap1_d;
            cap2_q         <= cap2_d;
            miso_sr_q      <= miso_sr_d;
        end
    end

    assign address      = address_q;
    assign data_wr      = data_wr_q;
    assign write_strobe = write_strobe_q;
    assign read_strobe  = read_strobe_q;
    assign MISO_OE      = miso_oe;
    assign MISO_OUT     = miso_oe & miso_sr_q[7];

endmodule

// File: tb/tb_spi_cmd_decoder.sv
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

    logic       clk = 1'b0;
    logic       RST_S1 = 1'b1;
    logic       SCLK_IN = 1'b0;
    logic       SCSN_IN = 1'b1;
    logic       MOSI_IN = 1'b0;
    logic       MISO_OUT, MISO_OE;
    logic [6:0] dev_addr = 7'h12;
    logic [7:0] address, data_wr;
    logic       write_strobe, read_strobe;
    logic [7:0] read_data = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:255];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [1:0]  oe_obs_q[$];
    logic [15:0] wr_obs_q[$];
    logic [7:0]  rd_obs_q[$];
    logic        both_seen = 1'b0;
    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  exp_rx_q[$];
    logic [1:0]  exp_oe_q[$];
    logic [19:0] rst_obs;
    logic [7:0]  d_bytes [0:7][0:4];
    int          d_bits  [0:7];

    spi_cmd_decoder dut (
        .SPI_CLK      (clk),
        .RST_S1       (RST_S1),
        .SCLK_IN      (SCLK_IN),
        .SCSN_IN      (SCSN_IN),
        .MOSI_IN      (MOSI_IN),
        .MISO_OUT     (MISO_OUT),
        .MISO_OE      (MISO_OE),
        .dev_addr     (dev_addr),
        .address      (address),
        .data_wr      (data_wr),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .read_data    (read_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    // register bank stand-in: data valid one cycle after read_strobe
    always @(posedge clk) begin
        if (read_strobe) read_data <= mem[address];
    end

    // strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (write_strobe) wr_obs_q.push_back({address, data_wr});
        if (read_strobe) rd_obs_q.push_back(address);
        if (write_strobe && read_strobe) both_seen = 1'b1;
    end

    // driver: SPI mode 0 master; rst_bit >= 0 pulses RST_S1 after that bit
    task automatic spi_frame(input int nbits, input int half, input int rst_bit);
        logic [7:0] cur, rx;
        logic any_oe, all_oe;
        rx_q.delete(); oe_obs_q.delete(); wr_obs_q.delete(); rd_obs_q.delete();
        both_seen = 1'b0;
        rx = 8'h00; any_oe = 1'b0; all_oe = 1'b1;
        SCSN_IN = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cur = tx_q[i / 8];
            MOSI_IN = cur[7 - (i % 8)];
            #(half);
            rx = {rx[6:0], MISO_OUT};
            any_oe = any_oe | MISO_OE;
            all_oe = all_oe & MISO_OE;
            SCLK_IN = 1'b1;
            #(half);
            SCLK_IN = 1'b0;
            if (i % 8 == 7) begin
                rx_q.push_back(rx);
                oe_obs_q.push_back({any_oe, all_oe});
                any_oe = 1'b0; all_oe = 1'b1;
            end
            if (i == rst_bit) begin
                #3 RST_S1 = 1'b1;
                #1 rst_obs = {address, data_wr, write_strobe, read_strobe, MISO_OUT, MISO_OE};
                #20 RST_S1 = 1'b0;
            end
        end
        #(half);
        SCSN_IN = 1'b1;
        MOSI_IN = 1'b0;
        #400;
    endtask

    // reference model: derives expected strobes and MISO bytes from the frame bytes
    task automatic model_frame(input int nbits);
        int nb;
        logic [7:0] b0, base;
        logic acc, rd;
        exp_wr_q.delete(); exp_rd_q.delete(); exp_rx_q.delete(); exp_oe_q.delete();
        nb = nbits / 8;
        b0 = tx_q[0];
        base = (tx_q.size() > 1) ? tx_q[1] : 8'h00;
        acc = (nb >= 1) && ((b0[7:1] == dev_addr) || (b0[7:1] == 7'h7F && !b0[0]));
        rd = acc && b0[0] && (b0[7:1] == dev_addr);
        for (int i = 0; i < nb; i++) begin
            if (rd && i >= 2) begin
                exp_oe_q.push_back(2'b11);
                exp_rx_q.push_back(mem[8'(int'(base) + i - 2)]);
            end else begin
                exp_oe_q.push_back(2'b00);
                exp_rx_q.push_back(8'h00);
            end
        end
        if (acc && nb >= 2) begin
            if (rd) begin
                for (int k = 0; k <= nb - 2; k++) exp_rd_q.push_back(8'(int'(base) + k));
            end else begin
                for (int i = 2; i < nb; i++) exp_wr_q.push_back({8'(int'(base) + i - 2), tx_q[i]});
            end
        end
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        obs = {address, data_wr, write_strobe, read_strobe, MISO_OUT, MISO_OE};
        checks++;
        if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", obs, 20'h0);
        end
        checks++;
        if (wr_obs_q.size() + rd_obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_strobes got %0d exp 0", wr_obs_q.size() + rd_obs_q.size());
        end
    endtask

    task automatic test_directed();
        d_bytes = '{'{8'h24, 8'h03, 8'hA5, 8'h00, 8'h00},   // write 0x03=A5
                    '{8'h25, 8'h05, 8'h00, 8'h00, 8'h00},   // read 0x05
                    '{8'h24, 8'hFE, 8'h01, 8'h02, 8'h03},   // burst with wrap
                    '{8'h26, 8'h05, 8'h77, 8'h00, 8'h00},   // other chip
                    '{8'hFE, 8'h03, 8'h08, 8'h00, 8'h00},   // broadcast write
                    '{8'hFF, 8'h03, 8'h00, 8'h00, 8'h00},   // broadcast read
                    '{8'h24, 8'h10, 8'h55, 8'h00, 8'h00},   // partial byte2
                    '{8'h24, 8'h11, 8'h66, 8'h00, 8'h00}};  // normal afterwards
        d_bits = '{24, 24, 40, 24, 24, 24, 20, 24};
        for (int e = 0; e < 8; e++) begin
            tx_q.delete();
            for (int j = 0; j < 5; j++) tx_q.push_back(d_bytes[e][j]);
            model_frame(d_bits[e]);
            spi_frame(d_bits[e], 60, -1);
            checks++;
            if (wr_obs_q.size() != exp_wr_q.size()) begin
                errors++;
                $display("FAIL dir%0d wr_count got %0d exp %0d", e, wr_obs_q.size(), exp_wr_q.size());
            end
            for (int k = 0; k < exp_wr_q.size() && k < wr_obs_q.size(); k++) begin
                checks++;
                if (wr_obs_q[k] !== exp_wr_q[k]) begin
                    errors++;
                    $display("FAIL dir%0d write%0d addr_data got %h exp %h", e, k, wr_obs_q[k], exp_wr_q[k]);
                end
            end
            checks++;
            if (rd_obs_q.size() != exp_rd_q.size()) begin
                errors++;
                $display("FAIL dir%0d rd_count got %0d exp %0d", e, rd_obs_q.size(), exp_rd_q.size());
            end
            for (int k = 0; k < exp_rd_q.size() && k < rd_obs_q.size(); k++) begin
                checks++;
                if (rd_obs_q[k] !== exp_rd_q[k]) begin
                    errors++;
                    $display("FAIL dir%0d read%0d addr got %h exp %h", e, k, rd_obs_q[k], exp_rd_q[k]);
                end
            end
            for (int k = 0; k < exp_rx_q.size() && k < rx_q.size(); k++) begin
                checks += 2;
                if (rx_q[k] !== exp_rx_q[k]) begin
                    errors++;
                    $display("FAIL dir%0d miso_byte%0d got %h exp %h", e, k, rx_q[k], exp_rx_q[k]);
                end
                if (oe_obs_q[k] !== exp_oe_q[k]) begin
                    errors++;
                    $display("FAIL dir%0d oe_byte%0d got %b exp %b", e, k, oe_obs_q[k], exp_oe_q[k]);
                end
            end
            checks++;
            if ({both_seen, MISO_OE} !== 2'b00) begin
                errors++;
                $display("FAIL dir%0d both_strobes_or_oe_after got %b exp 00", e, {both_seen, MISO_OE});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        // write frame interrupted by reset inside the register byte
        tx_q = '{8'h24, 8'h20, 8'h77};
        spi_frame(24, 70, 11);
        checks++;
        if (rst_obs !== 20'h0) begin
            errors++;
            $display("FAIL rst_mid outputs got %h exp %h", rst_obs, 20'h0);
        end
        checks++;
        if (wr_obs_q.size() + rd_obs_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid strobes got %0d exp 0", wr_obs_q.size() + rd_obs_q.size());
        end
        // the following frame must decode normally
        tx_q = '{8'h24, 8'h21, 8'h88};
        model_frame(24);
        spi_frame(24, 70, -1);
        checks++;
        if (wr_obs_q.size() != exp_wr_q.size() || rd_obs_q.size() != 0) begin
            errors++;
            $display("FAIL rst_after counts got %0d/%0d exp %0d/0", wr_obs_q.size(), rd_obs_q.size(), exp_wr_q.size());
        end else begin
            checks++;
            if (wr_obs_q[0] !== exp_wr_q[0]) begin
                errors++;
                $display("FAIL rst_after write got %h exp %h", wr_obs_q[0], exp_wr_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nbytes, nbits, half, sel;
        logic [6:0] dev;
        for (int f = 0; f < 16; f++) begin
            sel = $urandom_range(0, 3);
            dev = (sel == 1) ? 7'h7F : (sel == 2) ? 7'($urandom) : dev_addr;
            nbytes = $urandom_range(2, 5);
            nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(8, nbytes * 8 - 1) : nbytes * 8;
            half = 10 * $urandom_range(5, 9);
            tx_q.delete();
            tx_q.push_back({dev, 1'($urandom)});
            for (int j = 1; j < nbytes; j++) tx_q.push_back(8'($urandom));
            model_frame(nbits);
            spi_frame(nbits, half, -1);
            checks++;
            if (wr_obs_q.size() != exp_wr_q.size() || rd_obs_q.size() != exp_rd_q.size()) begin
                errors++;
                $display("FAIL rnd%0d counts wr/rd got %0d/%0d exp %0d/%0d", f,
                         wr_obs_q.size(), rd_obs_q.size(), exp_wr_q.size(), exp_rd_q.size());
            end
            for (int k = 0; k < exp_wr_q.size() && k < wr_obs_q.size(); k++) begin
                checks++;
                if (wr_obs_q[k] !== exp_wr_q[k]) begin
                    errors++;
                    $display("FAIL rnd%0d write%0d got %h exp %h", f, k, wr_obs_q[k], exp_wr_q[k]);
                end
            end
            for (int k = 0; k < exp_rd_q.size() && k < rd_obs_q.size(); k++) begin
                checks++;
                if (rd_obs_q[k] !== exp_rd_q[k]) begin
                    errors++;
                    $display("FAIL rnd%0d read%0d got %h exp %h", f, k, rd_obs_q[k], exp_rd_q[k]);
                end
            end
            for (int k = 0; k < exp_rx_q.size() && k < rx_q.size(); k++) begin
                checks += 2;
                if (rx_q[k] !== exp_rx_q[k]) begin
                    errors++;
                    $display("FAIL rnd%0d miso_byte%0d got %h exp %h", f, k, rx_q[k], exp_rx_q[k]);
                end
                if (oe_obs_q[k] !== exp_oe_q[k]) begin
                    errors++;
                    $display("FAIL rnd%0d oe_byte%0d got %b exp %b", f, k, oe_obs_q[k], exp_oe_q[k]);
                end
            end
            checks++;
            if (both_seen !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d both_strobes got %b exp 0", f, both_seen);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[5] = 8'h11;
        #37 RST_S1 = 1'b0;
        #50;
        test_reset();
        test_directed();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
